// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, active-window bounds and RGB565 colours
package vga_timing_pkg;
    typedef logic [15:0] rgb565_t;
    localparam int H_SYNC      = 96;
    localparam int H_BACK      = 48;
    localparam int H_VALID     = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 33;
    localparam int V_VALID     = 480;
    localparam int V_TOTAL     = 525;
    localparam int H_ACT_START = H_SYNC + H_BACK;
    localparam int H_ACT_END   = H_ACT_START + H_VALID;
    localparam int V_ACT_START = V_SYNC + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_VALID;
    localparam rgb565_t RED    = 16'hF800;
    localparam rgb565_t ORANGE = 16'hFC00;
    localparam rgb565_t YELLOW = 16'hFFE0;
    localparam rgb565_t GREEN  = 16'h07E0;
    localparam rgb565_t CYAN   = 16'h07FF;
    localparam rgb565_t BLUE   = 16'h001F;
    localparam rgb565_t PURPLE = 16'hF81F;
    localparam rgb565_t BLACK  = 16'h0000;
    localparam rgb565_t WHITE  = 16'hFFFF;
    localparam rgb565_t GRAY   = 16'hD69A;
endpackage

// File: rtl/pix_strobe_gen.sv
// pix_strobe_gen: divides sys_clk into a one-cycle pixel strobe every CLK_DIV cycles
module pix_strobe_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic pix_en
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        pix_en    = div_cnt_q == DW'(CLK_DIV - 1);
        div_cnt_d = pix_en ? '0 : div_cnt_q + DW'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) div_cnt_q <= '0;
        else            div_cnt_q <= div_cnt_d;
    end
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator producing sync, pixel requests/coordinates and gated RGB565 output
module vga_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_VALID = vga_timing_pkg::H_VALID,
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BACK  = vga_timing_pkg::V_BACK,
    parameter int V_VALID = vga_timing_pkg::V_VALID,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);
    import vga_timing_pkg::*;

    localparam int HA_S = H_SYNC + H_BACK;
    localparam int HA_E = HA_S + H_VALID;
    localparam int VA_S = V_SYNC + V_BACK;
    localparam int VA_E = VA_S + V_VALID;

    logic       pix_en;
    logic [9:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
    logic       frame_start_q, frame_start_d;
    logic       h_end, v_end, h_act, v_act, rgb_valid;

    pix_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .pix_en   (pix_en)
    );

    always_comb begin
        h_end         = cnt_h_q == 10'(H_TOTAL - 1);
        v_end         = cnt_v_q == 10'(V_TOTAL - 1);
        cnt_h_d       = pix_en ? (h_end ? '0 : cnt_h_q + 10'd1) : cnt_h_q;
        cnt_v_d       = (pix_en && h_end) ? (v_end ? '0 : cnt_v_q + 10'd1) : cnt_v_q;
        frame_start_d = pix_en && h_end && v_end;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Requests lead the visible window by one pixel so vga_pic's registered ROM data lines up with rgb.
    always_comb begin
        hsync       = cnt_h_q < 10'(H_SYNC);
        vsync       = cnt_v_q < 10'(V_SYNC);
        v_act       = cnt_v_q >= 10'(VA_S) && cnt_v_q < 10'(VA_E);
        h_act       = cnt_h_q >= 10'(HA_S) && cnt_h_q < 10'(HA_E);
        rgb_valid   = h_act && v_act;
        pix_req     = v_act && cnt_h_q >= 10'(HA_S - 1) && cnt_h_q < 10'(HA_E - 1);
        pix_x       = pix_req ? cnt_h_q - 10'(HA_S - 1) : 10'h3FF;
        pix_y       = pix_req ? cnt_v_q - 10'(VA_S) : 10'h3FF;
        rgb         = rgb_valid ? pix_data : BLACK;
        frame_start = frame_start_q;
    end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: checks vga_ctrl instances (full and shrunken timing, CLK_DIV 1/2/3) against a time-based reference model
module tb_vga_ctrl;
    localparam int S_HS = 4, S_HB = 3, S_HV = 10, S_HT = 20;
    localparam int S_VS = 2, S_VB = 2, S_VV = 5, S_VT = 12;

    typedef struct packed {
        logic       hs, vs, req, act, fs;
        logic [9:0] x, y;
        int         h, v;
    } exp_t;

    logic        clk = 0, rst_n = 0;
    logic [15:0] pd0 = '0, pd1, pd2 = '0, pd3 = 16'hF800;
    logic        hs[4], vs[4], req[4], fs[4];
    logic [9:0]  px[4], py[4];
    logic [15:0] rgb[4];
    longint      n;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    vga_ctrl #(.CLK_DIV(2)) d0 (.sys_clk(clk), .sys_rst_n(rst_n), .pix_data(pd0), .pix_req(req[0]),
        .pix_x(px[0]), .pix_y(py[0]), .hsync(hs[0]), .vsync(vs[0]), .rgb(rgb[0]), .frame_start(fs[0]));
    vga_ctrl #(.CLK_DIV(2), .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_TOTAL(S_HT),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_TOTAL(S_VT)) d1 (.sys_clk(clk), .sys_rst_n(rst_n),
        .pix_data(pd1), .pix_req(req[1]), .pix_x(px[1]), .pix_y(py[1]), .hsync(hs[1]), .vsync(vs[1]),
        .rgb(rgb[1]), .frame_start(fs[1]));
    vga_ctrl #(.CLK_DIV(1), .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_TOTAL(S_HT),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_TOTAL(S_VT)) d2 (.sys_clk(clk), .sys_rst_n(rst_n),
        .pix_data(pd2), .pix_req(req[2]), .pix_x(px[2]), .pix_y(py[2]), .hsync(hs[2]), .vsync(vs[2]),
        .rgb(rgb[2]), .frame_start(fs[2]));
    vga_ctrl #(.CLK_DIV(3), .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_TOTAL(S_HT),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_TOTAL(S_VT)) d3 (.sys_clk(clk), .sys_rst_n(rst_n),
        .pix_data(pd3), .pix_req(req[3]), .pix_x(px[3]), .pix_y(py[3]), .hsync(hs[3]), .vsync(vs[3]),
        .rgb(rgb[3]), .frame_start(fs[3]));

    // Expected outputs after nn clock edges since reset release, derived from elapsed pixel time.
    function automatic exp_t model(longint nn, int d, int ht, int hs_w, int hb, int hv,
                                   int vt, int vs_w, int vb, int vv);
        exp_t   e;
        longint p = nn / d;
        logic   va;
        e.h   = int'(p % ht);
        e.v   = int'((p / ht) % vt);
        e.hs  = e.h < hs_w;
        e.vs  = e.v < vs_w;
        va    = e.v >= vs_w + vb && e.v < vs_w + vb + vv;
        e.act = va && e.h >= hs_w + hb && e.h < hs_w + hb + hv;
        e.req = va && e.h >= hs_w + hb - 1 && e.h < hs_w + hb + hv - 1;
        e.x   = e.req ? 10'(e.h - (hs_w + hb - 1)) : 10'h3FF;
        e.y   = e.req ? 10'(e.v - (vs_w + vb)) : 10'h3FF;
        e.fs  = nn > 0 && nn % d == 0 && p % (ht * vt) == 0;
        return e;
    endfunction

    function automatic exp_t mdl(int i, longint nn);
        if (i == 0) return model(nn, 2, 800, 96, 48, 640, 525, 2, 33, 480);
        return model(nn, i == 2 ? 1 : (i == 3 ? 3 : 2), S_HT, S_HS, S_HB, S_HV, S_VT, S_VS, S_VB, S_VV);
    endfunction

    function automatic logic [15:0] exp_rgb(int i, exp_t e);
        if (!e.act) return 16'h0000;
        if (i == 0) return pd0;
        if (i == 1) return {6'(e.v - (S_VS + S_VB)), 10'(e.h - (S_HS + S_HB))};
        if (i == 2) return pd2;
        return 16'hF800;
    endfunction

    function automatic logic [15:0] vpic(exp_t e);
        return e.req ? {e.y[5:0], e.x} : 16'h0000;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) n <= 0;
        else        n <= n + 1;

    // vga_pic stand-in: registers the requested pixel's data on the strobe, so it appears one pixel later.
    always @(posedge clk or negedge rst_n)
        if (!rst_n)          pd1 <= '0;
        else if (n % 2 == 1) pd1 <= vpic(mdl(1, n));

    task automatic test_reset();
        #51;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({hs[i], vs[i], req[i], px[i], py[i], rgb[i], fs[i]} !== {3'b110, 20'hFFFFF, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_values dut%0d: got hs=%b vs=%b req=%b x=%h y=%h rgb=%h fs=%b, want 1 1 0 3ff 3ff 0000 0",
                         i, hs[i], vs[i], req[i], px[i], py[i], rgb[i], fs[i]);
            end
        end
        wait ($time >= 200);
        rst_n = 1;
    endtask

    task automatic test_timing(int cycles);
        exp_t e;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                e = mdl(i, n);
                checks++;
                if ({hs[i], vs[i], req[i], px[i], py[i], fs[i]} !== {e.hs, e.vs, e.req, e.x, e.y, e.fs}) begin
                    errors++;
                    $display("FAIL timing dut%0d n=%0d h=%0d v=%0d: got hs=%b vs=%b req=%b x=%h y=%h fs=%b, want %b %b %b %h %h %b",
                             i, n, e.h, e.v, hs[i], vs[i], req[i], px[i], py[i], fs[i], e.hs, e.vs, e.req, e.x, e.y, e.fs);
                end
                checks++;
                if (rgb[i] !== exp_rgb(i, e)) begin
                    errors++;
                    $display("FAIL rgb dut%0d n=%0d h=%0d v=%0d: got %h, want %h", i, n, e.h, e.v, rgb[i], exp_rgb(i, e));
                end
            end
            pd0 = 16'($urandom);
            pd2 = 16'($urandom);
        end
    endtask

    task automatic test_hsync_period();
        int  k = 0, hi = 0, per = 0;
        logic prev = hs[0];
        while (k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (hs[0] && !prev) break;
            prev = hs[0];
        end
        while (hs[0] && hi < 2000) begin
            hi++;
            per++;
            @(posedge clk);
            #1;
        end
        while (!hs[0] && per < 4000) begin
            per++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (hi !== 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d cycles, want 192", hi);
        end
        checks++;
        if (per !== 1600) begin
            errors++;
            $display("FAIL hsync_period: got %0d cycles, want 1600", per);
        end
    endtask

    task automatic test_window_edges();
        int  k = 0, nreq = 0, idle_bad = 0, max_x = 0, max_y = 0;
        logic first = 1;
        while (!fs[1] && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (!fs[1]) begin
            errors++;
            $display("FAIL frame_align dut1: no frame_start within 1000 cycles, want one");
        end
        for (int c = 0; c < 2 * S_HT * S_VT; c++) begin
            if (req[1]) begin
                if (first) begin
                    checks++;
                    if ({px[1], py[1]} !== 20'h0) begin
                        errors++;
                        $display("FAIL first_req dut1: got x=%0d y=%0d, want 0 0", px[1], py[1]);
                    end
                    first = 0;
                end
                nreq++;
                if (int'(px[1]) > max_x) max_x = int'(px[1]);
                if (int'(py[1]) > max_y) max_y = int'(py[1]);
            end else if ({px[1], py[1]} !== 20'hFFFFF) idle_bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (nreq !== 2 * S_HV * S_VV) begin
            errors++;
            $display("FAIL req_count dut1: got %0d, want %0d", nreq, 2 * S_HV * S_VV);
        end
        checks++;
        if (max_x !== S_HV - 1 || max_y !== S_VV - 1) begin
            errors++;
            $display("FAIL last_req dut1: got x=%0d y=%0d, want %0d %0d", max_x, max_y, S_HV - 1, S_VV - 1);
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL idle_coords dut1: got %0d cycles not 3ff, want 0", idle_bad);
        end
    endtask

    task automatic test_colour_window();
        int k = 0, red = 0, blk = 0, other = 0;
        while (!fs[3] && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int c = 0; c < 3 * S_HT * S_VT; c++) begin
            if (rgb[3] === 16'hF800) red++;
            else if (rgb[3] === 16'h0000) blk++;
            else other++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (red !== 3 * S_HV * S_VV || other !== 0) begin
            errors++;
            $display("FAIL colour_active dut3: got red=%0d other=%0d, want %0d 0", red, other, 3 * S_HV * S_VV);
        end
        checks++;
        if (blk !== 3 * (S_HT * S_VT - S_HV * S_VV)) begin
            errors++;
            $display("FAIL colour_blank dut3: got %0d, want %0d", blk, 3 * (S_HT * S_VT - S_HV * S_VV));
        end
    endtask

    task automatic test_mid_reset();
        int first_fs = -1, nfs = 0, first_low = -1;
        repeat ($urandom_range(100, 600)) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({hs[i], vs[i], req[i], px[i], py[i], rgb[i], fs[i]} !== {3'b110, 20'hFFFFF, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got hs=%b vs=%b req=%b x=%h y=%h rgb=%h fs=%b, want 1 1 0 3ff 3ff 0000 0",
                         i, hs[i], vs[i], req[i], px[i], py[i], rgb[i], fs[i]);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            if (fs[1]) begin
                nfs++;
                if (first_fs < 0) first_fs = k;
            end
            if (!hs[0] && first_low < 0) first_low = k;
        end
        checks++;
        if (first_fs !== 2 * S_HT * S_VT || nfs !== 2) begin
            errors++;
            $display("FAIL restart_frame dut1: got first=%0d count=%0d, want %0d 2", first_fs, nfs, 2 * S_HT * S_VT);
        end
        checks++;
        if (first_low !== 192) begin
            errors++;
            $display("FAIL restart_hsync dut0: got first low at %0d, want 192", first_low);
        end
    endtask

    initial begin
        test_reset();
        test_timing(4000);
        test_hsync_period();
        test_window_edges();
        test_colour_window();
        test_mid_reset();
        test_timing(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator; sits directly upstream of vga_pic inside rom_vga.
- Runs on sys_clk with an internal pixel strobe.
- Produces the pixel coordinates and the pixel request that vga_pic uses to read image ROM.
- Takes vga_pic's pixel data back and drives hsync, vsync and the final 16-bit RGB565 output.

Parameters:
- CLK_DIV, 2, sys_clk cycles per pixel (50 MHz / 2 = 25 MHz pixel rate); legal range 1..4
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines per frame
- V_TOTAL, 525, lines per frame

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- pix_data  in  16  RGB565 from vga_pic; valid one pixel after the matching pix_req
- pix_req  out  1  high one pixel ahead of each active pixel
- pix_x  out  10  column of the requested pixel; 10'h3FF when pix_req=0
- pix_y  out  10  row of the requested pixel; 10'h3FF when pix_req=0
- hsync  out  1  horizontal sync, active high
- vsync  out  1  vertical sync, active high
- rgb  out  16  pixel output; 0 outside the active window
- frame_start  out  1  one-sys_clk pulse at each frame wrap

Behaviour:
- Reset (async assert, sync release): div_cnt=0, cnt_h=0, cnt_v=0, frame_start=0.
- Decoded output values during reset follow from those counter values: hsync=1, vsync=1, pix_req=0, pix_x=pix_y=10'h3FF, rgb=0.
- pix_en:
  - high for one sys_clk when div_cnt==CLK_DIV-1; div_cnt wraps to 0 at that point.
  - With CLK_DIV=1, pix_en is permanently 1.
- Counters (update only on pix_en):
  - cnt_h increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap cnt_v increments; at V_TOTAL-1 it wraps to 0.
- All outputs are combinational decodes of the registered counters, except frame_start.
  - Outputs change only on the sys_clk edge following pix_en.
  - Outputs hold stable for CLK_DIV cycles.
- hsync = cnt_h < H_SYNC.
- vsync = cnt_v < V_SYNC.
- Vertical active: v_act = V_SYNC+V_BACK <= cnt_v < V_SYNC+V_BACK+V_VALID, i.e. cnt_v 35..514.
- Horizontal active: h_act = H_SYNC+H_BACK <= cnt_h < H_SYNC+H_BACK+H_VALID, i.e. cnt_h 144..783.
- rgb_valid = h_act & v_act.
- pix_req: same window shifted one pixel earlier horizontally (cnt_h 143..782), gated by v_act. No vertical lead.
- pix_x = cnt_h-(H_SYNC+H_BACK-1) and pix_y = cnt_v-(V_SYNC+V_BACK) while pix_req=1; both 10'h3FF otherwise.
- rgb = rgb_valid ? pix_data : 16'h0000.
  - Contract: vga_pic registers its ROM output on pix_en, so data for pix_req at pixel n is present at pixel n+1.
  - This block adds no extra pipeline stage.
- frame_start:
  - Registered; asserted for exactly one sys_clk on the edge where both counters wrap to 0.
  - Not asserted for the first frame after reset.
- Wrap boundaries:
  - cnt_h=799 → 0 and cnt_v=524 → 0 occur on the same pix_en edge.
  - No glitch on vsync; vsync rises on that edge.
- Mid-frame reset: all counters return to 0 immediately; the next frame restarts cleanly at cnt_h=cnt_v=0.
- Non-pixel cycles: with CLK_DIV>1, pix_data is sampled combinationally into rgb every cycle. vga_pic must hold it stable between strobes.
- Widths: counters are 10 bits; H_TOTAL and V_TOTAL must be ≤1024. Subtractions are 10-bit unsigned and are evaluated only inside the window.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants (H_*, V_*);
  - derived window bounds H_ACT_START=144, H_ACT_END=784, V_ACT_START=35, V_ACT_END=515;
  - the RGB565 colour constants shared with vga_pic.
- One sub-module, pix_strobe_gen: div_cnt and pix_en generation, parameter CLK_DIV.
- Everything else stays flat in vga_ctrl.

Test Plan:
- Release reset at 200 ns, CLK_DIV=2 → hsync high for 192 sys_clk, period 1600 sys_clk; vsync high for 3200 sys_clk, period 840000 sys_clk; first frame_start at 840000 sys_clk after release.
- Active-window edges → first pix_req=1 at cnt_h=143, cnt_v=35 with pix_x=0, pix_y=0; last at cnt_h=782 with pix_x=639; pix_y=479 on cnt_v=514; pix_x=pix_y=10'h3FF elsewhere.
- Drive pix_data=16'hF800 constant → rgb=16'hF800 exactly 640 pixels/line for 480 lines, 16'h0000 in all porch and sync regions.
- Model vga_pic returning pix_data={pix_y[5:0],pix_x[9:0]} one pixel late → rgb at cnt_h=144+k, cnt_v=35+j equals {j[5:0],k[9:0]} for sampled k, j.
- Pulse sys_rst_n low at cnt_h=400, cnt_v=200 → all outputs reach reset values within the same cycle; after release, hsync timing restarts from cnt_h=0 and there is no frame_start until the full frame completes.
- CLK_DIV=1 → hsync period 800 sys_clk, outputs change every cycle, window checks as above hold.
